// File: rtl/dilithium_sign_sequencer.sv
// Sequencer that drives one Dilithium core through a complete SIGN operation.
// It reads the key, message and seed words from a shared word-addressed operand RAM, streams
// them to the core in the order the core variant expects, then writes the z/h/c result words
// back into RAM.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   go_i, msg_len_i             start pulse and message length in bytes (sampled on accept)
//   busy_o, done_o, err_o       status: busy level, done pulse, rejected-go pulse
//   rd_en_o, rd_addr_o          RAM read port; data returns on rd_data_i one cycle later
//   wr_en_o, wr_addr_o,         RAM write port for the unloaded result words
//   wr_data_o
//   core_rst_o, core_start_o,   core control: reset, start pulse, constant mode
//   core_mode_o
//   core_valid_o, core_ready_i, core input stream
//   core_data_o
//   core_valid_i, core_ready_o, core output stream
//   core_data_i
module dilithium_sign_sequencer #(
    parameter int unsigned W          = 64,
    parameter int unsigned HIGH_PERF  = 1,
    parameter int unsigned ADDR_W     = 12,
    parameter logic [1:0]  MODE       = 2'd2,
    parameter int unsigned SEED_WORDS = 4,
    parameter int unsigned S1_WORDS   = 52,
    parameter int unsigned S2_WORDS   = 56,
    parameter int unsigned T0_WORDS   = 208,
    parameter int unsigned Z_WORDS    = 288,
    parameter int unsigned H_WORDS    = 11,
    parameter int unsigned MSG_MAX    = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              go_i,
    input  logic [W-1:0]      msg_len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [W-1:0]      rd_data_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [W-1:0]      wr_data_o,
    output logic              core_rst_o,
    output logic              core_start_o,
    output logic [1:0]        core_mode_o,
    output logic              core_valid_o,
    input  logic              core_ready_i,
    output logic [W-1:0]      core_data_o,
    input  logic              core_valid_i,
    output logic              core_ready_o,
    input  logic [W-1:0]      core_data_i
);

    localparam int unsigned Bpw    = W / 8;
    localparam int unsigned OffRho = 0;
    localparam int unsigned OffK   = SEED_WORDS;
    localparam int unsigned OffTr  = 2 * SEED_WORDS;
    localparam int unsigned OffS1  = 3 * SEED_WORDS;
    localparam int unsigned OffS2  = OffS1 + S1_WORDS;
    localparam int unsigned OffT0  = OffS2 + S2_WORDS;
    localparam int unsigned OffMsg = OffT0 + T0_WORDS;
    localparam int unsigned OffZ   = OffMsg + MSG_MAX;
    localparam int unsigned OffH   = OffZ + Z_WORDS;
    localparam int unsigned OffC   = OffH + H_WORDS;

    typedef enum logic [2:0] {StIdle, StCrst, StStart, StLoad, StDrain, StUnload, StDone} state_e;
    typedef enum logic [3:0] {
        SecRho, SecK, SecTr, SecS1, SecS2, SecT0, SecMlen, SecMsg, SecZ, SecH, SecC
    } sec_e;

    function automatic sec_e load_sec(input logic [2:0] idx);
        sec_e s;
        if (HIGH_PERF != 0) begin
            case (idx)
                3'd0:    s = SecRho;
                3'd1:    s = SecMlen;
                3'd2:    s = SecTr;
                3'd3:    s = SecMsg;
                3'd4:    s = SecK;
                3'd5:    s = SecS1;
                3'd6:    s = SecS2;
                default: s = SecT0;
            endcase
        end else begin
            case (idx)
                3'd0:    s = SecRho;
                3'd1:    s = SecK;
                3'd2:    s = SecTr;
                3'd3:    s = SecS1;
                3'd4:    s = SecS2;
                3'd5:    s = SecT0;
                3'd6:    s = SecMlen;
                default: s = SecMsg;
            endcase
        end
        return s;
    endfunction

    function automatic sec_e unload_sec(input logic [1:0] idx);
        sec_e s;
        if (HIGH_PERF != 0) begin
            case (idx)
                2'd0:    s = SecZ;
                2'd1:    s = SecH;
                default: s = SecC;
            endcase
        end else begin
            case (idx)
                2'd0:    s = SecC;
                2'd1:    s = SecZ;
                default: s = SecH;
            endcase
        end
        return s;
    endfunction

    function automatic logic [ADDR_W-1:0] sec_base(input sec_e s);
        logic [ADDR_W-1:0] b;
        case (s)
            SecRho:  b = ADDR_W'(OffRho);
            SecK:    b = ADDR_W'(OffK);
            SecTr:   b = ADDR_W'(OffTr);
            SecS1:   b = ADDR_W'(OffS1);
            SecS2:   b = ADDR_W'(OffS2);
            SecT0:   b = ADDR_W'(OffT0);
            SecMsg:  b = ADDR_W'(OffMsg);
            SecZ:    b = ADDR_W'(OffZ);
            SecH:    b = ADDR_W'(OffH);
            SecC:    b = ADDR_W'(OffC);
            default: b = '0;
        endcase
        return b;
    endfunction

    function automatic logic [ADDR_W-1:0] sec_len(input sec_e s, input logic [ADDR_W-1:0] mw);
        logic [ADDR_W-1:0] l;
        case (s)
            SecS1:   l = ADDR_W'(S1_WORDS);
            SecS2:   l = ADDR_W'(S2_WORDS);
            SecT0:   l = ADDR_W'(T0_WORDS);
            SecMlen: l = ADDR_W'(1);
            SecMsg:  l = mw;
            SecZ:    l = ADDR_W'(Z_WORDS);
            SecH:    l = ADDR_W'(H_WORDS);
            default: l = ADDR_W'(SEED_WORDS);
        endcase
        return l;
    endfunction

    state_e              r_state;
    logic                r_busy, r_done, r_err;
    logic                r_rd_en, r_wr_en;
    logic [ADDR_W-1:0]   r_rd_addr, r_wr_addr;
    logic [W-1:0]        r_wr_data;
    logic                r_core_rst, r_core_start, r_core_ready;
    logic [W-1:0]        r_msg_len;
    logic [ADDR_W-1:0]   r_mw;
    logic [1:0]          r_crst_cnt;
    logic [2:0]          r_sec_idx;
    logic [1:0]          r_usec;
    logic [ADDR_W-1:0]   r_word;
    // Two-stage read pipeline: r_iss = read strobe on the port, r_iss2 = data arriving now.
    logic                r_iss, r_iss_mlen, r_iss2, r_iss2_mlen;
    logic [W-1:0]        r_fifo [2];
    logic                r_fifo_wptr, r_fifo_rptr;
    logic [1:0]          r_fifo_cnt;

    logic [W-1:0]        w_mw_q, w_mw_full;
    logic                w_go_ok;
    sec_e                w_ld_sec, w_ul_sec;
    logic [ADDR_W-1:0]   w_ld_len, w_ld_addr, w_ul_len, w_ul_addr;
    logic                w_ld_last, w_ul_last, w_can_issue, w_push, w_pop;
    logic [W-1:0]        w_push_data;

    always_comb begin
        w_mw_q    = msg_len_i / W'(Bpw);
        w_mw_full = w_mw_q + W'((msg_len_i % W'(Bpw)) != '0);
        // An empty message still occupies one word.
        if (w_mw_full == '0) begin
            w_mw_full = W'(1);
        end
        w_go_ok = (w_mw_full <= W'(MSG_MAX));
    end

    always_comb begin
        w_ld_sec    = load_sec(r_sec_idx);
        w_ld_len    = sec_len(w_ld_sec, r_mw);
        w_ld_addr   = sec_base(w_ld_sec) + r_word;
        w_ld_last   = (r_word == w_ld_len - 1'b1);
        w_ul_sec    = unload_sec(r_usec);
        w_ul_len    = sec_len(w_ul_sec, r_mw);
        w_ul_addr   = sec_base(w_ul_sec) + r_word;
        w_ul_last   = (r_word == w_ul_len - 1'b1);
        // Reserve a FIFO slot for every read in flight so the 2-entry skid never overflows.
        w_can_issue = (r_state == StLoad) &&
                      (({1'b0, r_fifo_cnt} + 3'(r_iss) + 3'(r_iss2)) < 3'd2);
        w_push      = r_iss2;
        w_push_data = r_iss2_mlen ? r_msg_len : rd_data_i;
        w_pop       = (r_fifo_cnt != 2'd0) && core_ready_i;
    end

    assign busy_o       = r_busy;
    assign done_o       = r_done;
    assign err_o        = r_err;
    assign rd_en_o      = r_rd_en;
    assign rd_addr_o    = r_rd_addr;
    assign wr_en_o      = r_wr_en;
    assign wr_addr_o    = r_wr_addr;
    assign wr_data_o    = r_wr_data;
    assign core_rst_o   = r_core_rst;
    assign core_start_o = r_core_start;
    assign core_mode_o  = MODE;
    assign core_valid_o = (r_fifo_cnt != 2'd0);
    assign core_data_o  = r_fifo[r_fifo_rptr];
    assign core_ready_o = r_core_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_rd_en      <= 1'b0;
            r_rd_addr    <= '0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_core_rst   <= 1'b1;
            r_core_start <= 1'b0;
            r_core_ready <= 1'b0;
            r_msg_len    <= '0;
            r_mw         <= '0;
            r_crst_cnt   <= '0;
            r_sec_idx    <= '0;
            r_usec       <= '0;
            r_word       <= '0;
            r_iss        <= 1'b0;
            r_iss_mlen   <= 1'b0;
            r_iss2       <= 1'b0;
            r_iss2_mlen  <= 1'b0;
            r_fifo[0]    <= '0;
            r_fifo[1]    <= '0;
            r_fifo_wptr  <= 1'b0;
            r_fifo_rptr  <= 1'b0;
            r_fifo_cnt   <= '0;
        end else begin
            r_err        <= 1'b0;
            r_done       <= 1'b0;
            r_core_start <= 1'b0;
            r_rd_en      <= 1'b0;
            r_wr_en      <= 1'b0;
            r_iss        <= 1'b0;
            r_iss_mlen   <= 1'b0;
            r_iss2       <= r_iss;
            r_iss2_mlen  <= r_iss_mlen;

            if (w_push) begin
                r_fifo[r_fifo_wptr] <= w_push_data;
                r_fifo_wptr         <= ~r_fifo_wptr;
            end
            if (w_pop) begin
                r_fifo_rptr <= ~r_fifo_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + 2'd1;
                2'b01:   r_fifo_cnt <= r_fifo_cnt - 2'd1;
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase

            if (go_i && (r_state != StIdle)) begin
                r_err <= 1'b1;
            end

            case (r_state)
                StIdle: begin
                    if (go_i) begin
                        if (w_go_ok) begin
                            r_msg_len  <= msg_len_i;
                            r_mw       <= ADDR_W'(w_mw_full);
                            r_busy     <= 1'b1;
                            r_core_rst <= 1'b1;
                            r_crst_cnt <= '0;
                            r_state    <= StCrst;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                StCrst: begin
                    if (r_crst_cnt == 2'd3) begin
                        r_core_rst   <= 1'b0;
                        r_core_start <= 1'b1;
                        r_state      <= StStart;
                    end else begin
                        r_crst_cnt <= r_crst_cnt + 2'd1;
                    end
                end
                StStart: begin
                    r_sec_idx <= '0;
                    r_word    <= '0;
                    r_state   <= StLoad;
                end
                StLoad: begin
                    if (w_can_issue) begin
                        // MLEN travels the read pipeline without touching RAM to keep ordering.
                        r_iss      <= 1'b1;
                        r_iss_mlen <= (w_ld_sec == SecMlen);
                        r_rd_en    <= (w_ld_sec != SecMlen);
                        r_rd_addr  <= w_ld_addr;
                        if (w_ld_last) begin
                            r_word <= '0;
                            if (r_sec_idx == 3'd7) begin
                                r_state <= StDrain;
                            end else begin
                                r_sec_idx <= r_sec_idx + 3'd1;
                            end
                        end else begin
                            r_word <= r_word + 1'b1;
                        end
                    end
                end
                StDrain: begin
                    if ((r_fifo_cnt == 2'd0) && !r_iss && !r_iss2) begin
                        r_usec       <= '0;
                        r_word       <= '0;
                        r_core_ready <= 1'b1;
                        r_state      <= StUnload;
                    end
                end
                StUnload: begin
                    if (core_valid_i && r_core_ready) begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= w_ul_addr;
                        r_wr_data <= core_data_i;
                        if (w_ul_last) begin
                            r_word <= '0;
                            if (r_usec == 2'd2) begin
                                r_core_ready <= 1'b0;
                                r_state      <= StDone;
                            end else begin
                                r_usec <= r_usec + 2'd1;
                            end
                        end else begin
                            r_word <= r_word + 1'b1;
                        end
                    end
                end
                StDone: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_dilithium_sign_sequencer.sv
// Bench for dilithium_sign_sequencer: instance 0 is the high-perf variant, instance 1 the
// low-res variant. Expected core-input words and RAM writes are queued when an operation is
// launched; a monitor pops and compares them as the DUTs present words.
module tb_dilithium_sign_sequencer;

    localparam int W  = 64;
    localparam int AW = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          go      [2];
    logic [W-1:0]  msg_len [2];
    logic          busy    [2];
    logic          done    [2];
    logic          err     [2];
    logic          rd_en   [2];
    logic [AW-1:0] rd_addr [2];
    logic [W-1:0]  rd_data [2];
    logic          wr_en   [2];
    logic [AW-1:0] wr_addr [2];
    logic [W-1:0]  wr_data [2];
    logic          core_rst   [2];
    logic          core_start [2];
    logic [1:0]    core_mode  [2];
    logic          cvo [2];
    logic          cri [2];
    logic [W-1:0]  cdo [2];
    logic          cvi [2];
    logic          cro [2];
    logic [W-1:0]  cdi [2];

    logic [W-1:0]    mem [4096];
    logic [W-1:0]    exp_ld_q [2][$];
    logic [AW+W-1:0] exp_wr_q [2][$];

    int checks = 0;
    int errors = 0;
    int done_cnt [2];
    int err_cnt  [2];
    int start_cnt[2];
    int rst_run  [2];
    int rst_len  [2];
    int k_cnt    [2];
    int opid     [2];
    bit rnd_rdy  [2];
    bit rnd_vld  [2];
    bit hs_pend  [2];
    bit prev_stall [2];
    logic [W-1:0] prev_data [2];

    function automatic logic [W-1:0] ram_word(input int a);
        return {16'hA5C3, 4'h0, 12'(a), 32'(a) * 32'h9E3779B1};
    endfunction

    function automatic logic [W-1:0] core_word(input int i, input int op, input int k);
        return {4'hD, 4'(i), 8'(op), 16'h0, 32'(k)};
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        dilithium_sign_sequencer #(.HIGH_PERF(g == 0 ? 1 : 0)) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .go_i         (go[g]),
            .msg_len_i    (msg_len[g]),
            .busy_o       (busy[g]),
            .done_o       (done[g]),
            .err_o        (err[g]),
            .rd_en_o      (rd_en[g]),
            .rd_addr_o    (rd_addr[g]),
            .rd_data_i    (rd_data[g]),
            .wr_en_o      (wr_en[g]),
            .wr_addr_o    (wr_addr[g]),
            .wr_data_o    (wr_data[g]),
            .core_rst_o   (core_rst[g]),
            .core_start_o (core_start[g]),
            .core_mode_o  (core_mode[g]),
            .core_valid_o (cvo[g]),
            .core_ready_i (cri[g]),
            .core_data_o  (cdo[g]),
            .core_valid_i (cvi[g]),
            .core_ready_o (cro[g]),
            .core_data_i  (cdi[g])
        );
    end

    // Synchronous-read RAM model, one read port per instance.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rd_en[i]) rd_data[i] <= mem[rd_addr[i]];
        end
    end

    // Core model: random or constant handshake signals, output word index advances per handshake.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 2; i++) begin
            if (hs_pend[i]) k_cnt[i]++;
            cri[i] = rnd_rdy[i] ? 1'($urandom_range(0, 1)) : 1'b1;
            cvi[i] = rnd_vld[i] ? 1'($urandom_range(0, 1)) : 1'b1;
            cdi[i] = core_word(i, opid[i], k_cnt[i]);
        end
    end

    // Monitor: pops expectations whenever a DUT presents a word.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                prev_stall[i] = 1'b0;
                hs_pend[i]    = 1'b0;
                rst_run[i]    = 0;
            end else begin
                if (prev_stall[i]) begin
                    check($sformatf("hold_valid%0d", i), W'(cvo[i]), 64'd1);
                    check($sformatf("hold_data%0d", i), cdo[i], prev_data[i]);
                end
                prev_stall[i] = cvo[i] && !cri[i];
                prev_data[i]  = cdo[i];
                if (cvo[i] && cri[i]) begin
                    if (exp_ld_q[i].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_load%0d: got %h expected no word", i, cdo[i]);
                    end else begin
                        check($sformatf("load%0d", i), cdo[i], exp_ld_q[i].pop_front());
                    end
                end
                if (wr_en[i]) begin
                    if (exp_wr_q[i].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_write%0d: got %h expected no write", i, wr_data[i]);
                    end else begin
                        logic [AW+W-1:0] e;
                        e = exp_wr_q[i].pop_front();
                        check($sformatf("wr_addr%0d", i), W'(wr_addr[i]), W'(e[AW+W-1:W]));
                        check($sformatf("wr_data%0d", i), wr_data[i], e[W-1:0]);
                    end
                end
                if (done[i]) done_cnt[i]++;
                if (err[i]) err_cnt[i]++;
                if (core_start[i]) start_cnt[i]++;
                if (core_rst[i]) begin
                    rst_run[i]++;
                end else begin
                    if (rst_run[i] != 0) rst_len[i] = rst_run[i];
                    rst_run[i] = 0;
                end
                hs_pend[i] = cvi[i] && cro[i];
            end
        end
    end

    task automatic queue_expect(input int i, input logic [W-1:0] len, input int op);
        int ord[8];
        int base[8];
        int lens[8];
        int ubase[3];
        int ulen[3];
        int mw;
        int k;
        base = '{0, 4, 8, 12, 64, 120, 0, 328};
        lens = '{4, 4, 4, 52, 56, 208, 1, 0};
        mw = int'(len / 8) + ((len % 8) != 0 ? 1 : 0);
        if (mw == 0) mw = 1;
        lens[7] = mw;
        if (i == 0) begin
            ord   = '{0, 6, 2, 7, 1, 3, 4, 5};
            ubase = '{392, 680, 691};
            ulen  = '{288, 11, 4};
        end else begin
            ord   = '{0, 1, 2, 3, 4, 5, 6, 7};
            ubase = '{691, 392, 680};
            ulen  = '{4, 288, 11};
        end
        for (int s = 0; s < 8; s++) begin
            if (ord[s] == 6) begin
                exp_ld_q[i].push_back(len);
            end else begin
                for (int w = 0; w < lens[ord[s]]; w++) begin
                    exp_ld_q[i].push_back(mem[base[ord[s]] + w]);
                end
            end
        end
        k = 0;
        for (int s = 0; s < 3; s++) begin
            for (int w = 0; w < ulen[s]; w++) begin
                exp_wr_q[i].push_back({AW'(ubase[s] + w), core_word(i, op, k)});
                k++;
            end
        end
        opid[i]  = op;
        k_cnt[i] = 0;
    endtask

    task automatic pulse_go(input int i, input logic [W-1:0] len);
        @(posedge clk);
        #1;
        go[i]      = 1'b1;
        msg_len[i] = len;
        @(posedge clk);
        #1;
        go[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input int target, input string name);
        int n;
        n = 0;
        while (done_cnt[i] < target && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_done"}, W'(done_cnt[i]), W'(target));
        repeat (2) @(negedge clk);
        check({name, "_ld_left"}, W'(exp_ld_q[i].size()), 64'd0);
        check({name, "_wr_left"}, W'(exp_wr_q[i].size()), 64'd0);
        check({name, "_busy"}, W'(busy[i]), 64'd0);
    endtask

    task automatic check_reset(input int i, input string tag);
        check({tag, "_busy"}, W'(busy[i]), 64'd0);
        check({tag, "_done"}, W'(done[i]), 64'd0);
        check({tag, "_err"}, W'(err[i]), 64'd0);
        check({tag, "_rd_en"}, W'(rd_en[i]), 64'd0);
        check({tag, "_rd_addr"}, W'(rd_addr[i]), 64'd0);
        check({tag, "_wr_en"}, W'(wr_en[i]), 64'd0);
        check({tag, "_wr_addr"}, W'(wr_addr[i]), 64'd0);
        check({tag, "_wr_data"}, wr_data[i], 64'd0);
        check({tag, "_core_rst"}, W'(core_rst[i]), 64'd1);
        check({tag, "_core_start"}, W'(core_start[i]), 64'd0);
        check({tag, "_core_valid"}, W'(cvo[i]), 64'd0);
        check({tag, "_core_data"}, cdo[i], 64'd0);
        check({tag, "_core_ready"}, W'(cro[i]), 64'd0);
    endtask

    initial begin
        int e0;
        int d0;
        int n;
        for (int a = 0; a < 4096; a++) mem[a] = ram_word(a);
        for (int i = 0; i < 2; i++) begin
            go[i]        = 1'b0;
            msg_len[i]   = '0;
            done_cnt[i]  = 0;
            err_cnt[i]   = 0;
            start_cnt[i] = 0;
            rst_len[i]   = 0;
            opid[i]      = 0;
            k_cnt[i]     = 0;
            rnd_rdy[i]   = 1'b0;
            rnd_vld[i]   = 1'b0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset(0, "rst0");
        check_reset(1, "rst1");
        check("mode0", W'(core_mode[0]), 64'd2);
        @(negedge clk);
        rst_n = 1'b1;

        // High-perf, 33-byte message: 5 msg words.
        queue_expect(0, 64'd33, 1);
        pulse_go(0, 64'd33);
        wait_done(0, 1, "hp33");
        check("hp33_start", W'(start_cnt[0]), 64'd1);

        // Empty message still sends one msg word after MLEN=0.
        queue_expect(0, 64'd0, 2);
        pulse_go(0, 64'd0);
        wait_done(0, 2, "hp0");
        check("hp0_crst_len", W'(rst_len[0]), 64'd4);

        // Random backpressure on the input stream and gaps on the output stream.
        rnd_rdy[0] = 1'b1;
        rnd_vld[0] = 1'b1;
        queue_expect(0, 64'd20, 3);
        pulse_go(0, 64'd20);
        wait_done(0, 3, "hp_rnd");
        rnd_rdy[0] = 1'b0;
        rnd_vld[0] = 1'b0;

        // Low-res variant ordering.
        queue_expect(1, 64'd8, 4);
        pulse_go(1, 64'd8);
        wait_done(1, 1, "lr8");
        rnd_rdy[1] = 1'b1;
        queue_expect(1, 64'd60, 5);
        pulse_go(1, 64'd60);
        wait_done(1, 2, "lr_rnd");
        rnd_rdy[1] = 1'b0;

        // go while busy: one err pulse, operation unaffected.
        e0 = err_cnt[0];
        queue_expect(0, 64'd16, 6);
        pulse_go(0, 64'd16);
        repeat (60) @(negedge clk);
        pulse_go(0, 64'd600);
        wait_done(0, 4, "busy_go");
        check("busy_go_err", W'(err_cnt[0] - e0), 64'd1);

        // Oversized message: rejected, stays idle.
        e0 = err_cnt[0];
        d0 = done_cnt[0];
        pulse_go(0, 64'd513);
        repeat (8) @(negedge clk);
        check("big_err", W'(err_cnt[0] - e0), 64'd1);
        check("big_busy", W'(busy[0]), 64'd0);
        check("big_rd_en", W'(rd_en[0]), 64'd0);
        check("big_done", W'(done_cnt[0] - d0), 64'd0);

        // Reset during the s2 section, then a clean operation.
        queue_expect(0, 64'd8, 7);
        pulse_go(0, 64'd8);
        n = 0;
        while (!(rd_en[0] && rd_addr[0] >= 12'd64 && rd_addr[0] < 12'd120) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("s2_reached", W'(n < 5000), 64'd1);
        rst_n = 1'b0;
        #1;
        check_reset(0, "midrst");
        exp_ld_q[0].delete();
        exp_wr_q[0].delete();
        k_cnt[0] = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        d0 = done_cnt[0];
        queue_expect(0, 64'd40, 8);
        pulse_go(0, 64'd40);
        wait_done(0, d0 + 1, "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
